// File: rtl/stb_req_seq.sv
// stb_req_seq: strobe-request initiator running a burst of N strobe samples with timeout and settle.
// Optional STB_REQ_SEQ_ABORT_EN adds abort_i to terminate a burst early with err_code 3.
module stb_req_seq #(
  parameter int CNT_WIDTH = 16,
  parameter int TO_WIDTH  = 32,
  parameter int SET_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  input  logic [SET_WIDTH-1:0] settle_i,
  input  logic                 gen_rdy_i,
  input  logic                 stb_valid_i,
  input  logic                 cmp_i,
`ifdef STB_REQ_SEQ_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 stb_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_code_o,
  output logic [CNT_WIDTH-1:0] hits_o,
  output logic [CNT_WIDTH-1:0] samples_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, WAIT_VALID, SETTLE, SAMPLE, RELEASE, FINISH} state_e;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] n_q, hits_q, samples_q;
  logic [TO_WIDTH-1:0]  to_q, to_cnt_q;
  logic [SET_WIDTH-1:0] set_q, set_cnt_q;
  logic [1:0]           err_q, cmp_sync_q;
  logic                 req_q, busy_q, done_q, abort, to_hit;
`ifdef STB_REQ_SEQ_ABORT_EN
  assign abort = abort_i && state_q != IDLE && state_q != FINISH;
`else
  assign abort = 1'b0;
`endif
  // to_cnt_q holds completed wait cycles, so +1 is the cycle being spent now
  assign to_hit = to_q != '0 && to_cnt_q + TO_WIDTH'(1) == to_q;
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      n_q        <= '0;
      hits_q     <= '0;
      samples_q  <= '0;
      to_q       <= '0;
      to_cnt_q   <= '0;
      set_q      <= '0;
      set_cnt_q  <= '0;
      err_q      <= 2'd0;
      cmp_sync_q <= 2'b00;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      cmp_sync_q <= {cmp_sync_q[0], cmp_i};
      if (abort) begin
        req_q   <= 1'b0;
        err_q   <= 2'd3;
        state_q <= FINISH;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            n_q       <= n_samples_i;
            to_q      <= timeout_i;
            set_q     <= settle_i;
            hits_q    <= '0;
            samples_q <= '0;
            busy_q    <= 1'b1;
            err_q     <= gen_rdy_i ? 2'd0 : 2'd2;
            state_q   <= (!gen_rdy_i || n_samples_i == '0) ? FINISH : REQ;
          end
          REQ: begin
            req_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= WAIT_LOW;
          end
          WAIT_LOW, WAIT_VALID: begin
            if (to_hit) begin
              req_q   <= 1'b0;
              err_q   <= 2'd1;
              state_q <= FINISH;
            end else begin
              if (to_q != '0) to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
              // a valid still high from the previous strobe must first drop
              if (state_q == WAIT_LOW && !stb_valid_i) state_q <= WAIT_VALID;
              else if (state_q == WAIT_VALID && stb_valid_i) begin
                set_cnt_q <= SET_WIDTH'(1);
                state_q   <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (set_q == '0 || set_cnt_q == set_q) state_q <= SAMPLE;
            else set_cnt_q <= set_cnt_q + SET_WIDTH'(1);
          end
          SAMPLE: begin
            if (!stb_valid_i) begin
              req_q   <= 1'b0;
              err_q   <= 2'd1;
              state_q <= FINISH;
            end else begin
              hits_q    <= hits_q + CNT_WIDTH'(cmp_sync_q[1]);
              samples_q <= samples_q + CNT_WIDTH'(1);
              state_q   <= RELEASE;
            end
          end
          RELEASE: begin
            req_q   <= 1'b0;
            state_q <= samples_q == n_q ? FINISH : REQ;
          end
          FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign stb_req_o  = req_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_code_o = err_q;
  assign hits_o     = hits_q;
  assign samples_o  = samples_q;
endmodule

// File: tb/tb_stb_req_seq.sv
// tb_stb_req_seq: table-driven bench for stb_req_seq with a behavioural strobe-generator model.
module tb_stb_req_seq;
  logic        clk_i = 1'b0;
  logic        arstn_i, start_i, gen_rdy_i, stb_valid_i, cmp_i;
  logic [15:0] n_samples_i;
  logic [31:0] timeout_i;
  logic [7:0]  settle_i;
`ifdef STB_REQ_SEQ_ABORT_EN
  logic        abort_i;
`endif
  logic        stb_req_o, busy_o, done_o;
  logic [1:0]  err_code_o;
  logic [15:0] hits_o, samples_o;

  stb_req_seq dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_i(start_i), .n_samples_i(n_samples_i),
    .timeout_i(timeout_i), .settle_i(settle_i), .gen_rdy_i(gen_rdy_i),
    .stb_valid_i(stb_valid_i), .cmp_i(cmp_i),
`ifdef STB_REQ_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .stb_req_o(stb_req_o), .busy_o(busy_o), .done_o(done_o), .err_code_o(err_code_o),
    .hits_o(hits_o), .samples_o(samples_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  // generator model configuration, written only by the stimulus process
  logic       restore = 1'b1;
  logic [7:0] pat = 8'h00;
  int         drop_at = 2;
  // model state and observation counters, written only by the model process
  int   ctr = 0, kidx = 0, rises = 0, hi_cyc = 0, dones = 0, smp_at_drop = -1;
  logic req_d = 1'b0;

  always @(negedge clk_i) begin
    if (!busy_o) begin
      stb_valid_i = 1'b1;
      ctr = 0;
      kidx = 0;
    end else begin
      if (stb_req_o && !req_d) begin
        ctr = 1;
        cmp_i = pat[kidx];
        kidx++;
      end else if (ctr != 0) ctr++;
      if (ctr == drop_at) begin
        stb_valid_i = 1'b0;
        smp_at_drop = int'(samples_o);
      end
      if (restore && ctr == drop_at + 10) begin
        stb_valid_i = 1'b1;
        ctr = 0;
      end
    end
    if (stb_req_o && !req_d) rises++;
    if (stb_req_o) hi_cyc++;
    if (done_o) dones++;
    req_d = stb_req_o;
  end

  typedef struct {
    logic       rdy;
    int         n, settle, tmo;
    logic       rest;
    logic [7:0] pat;
    int         hits, smp, err, pulses, lat, hi;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic begin_burst(input logic rdy, input int n, input int s, input int t);
    @(negedge clk_i);
    gen_rdy_i   = rdy;
    n_samples_i = 16'(n);
    settle_i    = 8'(s);
    timeout_i   = 32'(t);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = 1;
    while (!done_o && lat < 3000) begin
      @(negedge clk_i);
      lat++;
    end
    if (!done_o) chk({nm, "_done_timeout"}, 0, 1);
    @(negedge clk_i);
  endtask

  initial begin
    int r0, h0, d0, lat;
    vecs[0] = '{1'b1, 4, 2, 0,   1'b1, 8'b1101, 3, 4, 0, 4, -1, -1};
    vecs[1] = '{1'b1, 0, 2, 0,   1'b1, 8'b0000, 0, 0, 0, 0,  2, -1};
    vecs[2] = '{1'b0, 3, 2, 0,   1'b1, 8'b0000, 0, 0, 2, 0,  2, -1};
    vecs[3] = '{1'b1, 3, 1, 50,  1'b0, 8'b0000, 0, 0, 1, 1, -1, 50};
    vecs[4] = '{1'b1, 2, 0, 100, 1'b1, 8'b0000, 0, 2, 0, 2, -1, -1};
    vecs[5] = '{1'b1, 3, 5, 20,  1'b1, 8'b0111, 3, 3, 0, 3, -1, -1};
    vecs[6] = '{1'b1, 2, 2, 5,   1'b1, 8'b0011, 0, 0, 1, 1, -1, 5};
    arstn_i = 1'b0; start_i = 1'b0; gen_rdy_i = 1'b1; cmp_i = 1'b0;
    n_samples_i = '0; timeout_i = '0; settle_i = '0;
`ifdef STB_REQ_SEQ_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {stb_req_o, busy_o, done_o, err_code_o, hits_o, samples_o}, 0);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      restore = vecs[i].rest;
      pat     = vecs[i].pat;
      drop_at = 2;
      r0 = rises; h0 = hi_cyc; d0 = dones;
      begin_burst(vecs[i].rdy, vecs[i].n, vecs[i].settle, vecs[i].tmo);
      wait_done($sformatf("v%0d", i), lat);
      chk($sformatf("v%0d_hits", i), hits_o, vecs[i].hits);
      chk($sformatf("v%0d_samples", i), samples_o, vecs[i].smp);
      chk($sformatf("v%0d_err", i), err_code_o, vecs[i].err);
      chk($sformatf("v%0d_req_pulses", i), rises - r0, vecs[i].pulses);
      chk($sformatf("v%0d_done_pulses", i), dones - d0, 1);
      chk($sformatf("v%0d_idle_after", i), {busy_o, done_o, stb_req_o}, 0);
      if (vecs[i].lat >= 0) chk($sformatf("v%0d_done_latency", i), lat, vecs[i].lat);
      if (vecs[i].hi >= 0) chk($sformatf("v%0d_req_high_cycles", i), hi_cyc - h0, vecs[i].hi);
    end

    // stale valid: generator keeps valid high for a while after the request rises
    restore = 1'b1; pat = 8'b1; drop_at = 6;
    begin_burst(1'b1, 1, 0, 0);
    wait_done("stale", lat);
    chk("stale_samples_at_drop", smp_at_drop, 0);
    chk("stale_samples", samples_o, 1);
    chk("stale_hits", hits_o, 1);
    drop_at = 2;

    // start while busy must not restart or alter the burst
    r0 = rises; pat = 8'b10;
    begin_burst(1'b1, 2, 2, 0);
    repeat (5) @(negedge clk_i);
    n_samples_i = 16'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("busy_start", lat);
    chk("busy_start_samples", samples_o, 2);
    chk("busy_start_hits", hits_o, 1);
    chk("busy_start_pulses", rises - r0, 2);

    // asynchronous reset mid-burst
    begin_burst(1'b1, 4, 2, 0);
    repeat (3) @(negedge clk_i);
    chk("areset_req_before", stb_req_o, 1);
    #2 arstn_i = 1'b0;
    #1 chk("areset_req_drop", stb_req_o, 0);
    chk("areset_state", {busy_o, err_code_o, hits_o, samples_o}, 0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

`ifdef STB_REQ_SEQ_ABORT_EN
    begin
      int k = 0;
      pat = 8'b11111;
      begin_burst(1'b1, 5, 2, 0);
      while (samples_o != 16'd2 && k < 500) begin
        @(negedge clk_i);
        k++;
      end
      chk("abort_reached_two", samples_o, 2);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_req_low", stb_req_o, 0);
      wait_done("abort", lat);
      chk("abort_err", err_code_o, 3);
      chk("abort_samples", samples_o, 2);
      chk("abort_hits", hits_o, 2);
      d0 = dones;
      abort_i = 1'b1;
      repeat (2) @(negedge clk_i);
      abort_i = 1'b0;
      @(negedge clk_i);
      chk("abort_idle_ignored", {busy_o, dones - d0}, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
